// File: rtl/ddr_rw_burst_scheduler_pkg.sv
// Shared types and helpers for the DDR read/write burst scheduler.
// Package name: ddr_sched_pkg.
`timescale 1ns/1ps
package ddr_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Channel identifiers, used for grants and round-robin history.
  typedef enum logic {
    CH_WR = 1'b0,
    CH_RD = 1'b1
  } ch_e;

  // Bytes covered by one burst. This is the amount the frame offset advances per burst.
  function automatic int burst_bytes(input int burst_len, input int beat_bytes);
    return burst_len * beat_bytes;
  endfunction

endpackage

// File: rtl/ddr_rw_burst_scheduler_if.sv
// Burst request/handshake bundle between the scheduler and the DDR AXI engine.
`timescale 1ns/1ps
interface ddr_rw_burst_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_ack;
  logic                  wr_done;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_done;

  // Scheduler side: issues requests and observes the engine handshake.
  modport master (
    output wr_req, wr_addr, rd_req, rd_addr,
    input  wr_ack, wr_done, rd_ack, rd_done
  );

  // Engine side: accepts requests and reports completion.
  modport slave (
    input  wr_req, wr_addr, rd_req, rd_addr,
    output wr_ack, wr_done, rd_ack, rd_done
  );
endinterface

// File: rtl/ddr_rw_burst_scheduler_addr_gen.sv
// Per-channel frame address generator. It captures the frame base at the first
// burst of a frame and tracks the burst index and byte offset. It detects the
// last burst of the frame and raises frame_end during the DONE cycle of that burst.
`timescale 1ns/1ps
module ddr_burst_addr_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_BYTES = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,        // burst granted to this channel
  input  logic                  advance,      // this channel's burst completed (DONE)
  input  logic                  clear,        // scheduler disabled: restart frame
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [15:0]           frame_bursts,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  frame_end
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_BYTES);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [15:0]           index_q;
  logic [15:0]           limit_m1;
  logic                  is_last;

  // Frame limit (0 counts as 1), wrap detection and the wrapping address sum.
  // NOTE: every always_comb output gets a default or a full assignment first, so no latch is inferred.
  always_comb begin
    limit_m1  = (frame_bursts == 16'd0) ? 16'd0 : frame_bursts - 16'd1;
    is_last   = (index_q >= limit_m1);
    frame_end = advance && is_last;
    addr      = base_q + offset_q;
  end

  // Base capture on the first burst of a frame. Index and offset advance on completion.
  // NOTE: state registers use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      offset_q <= '0;
      index_q  <= '0;
    end else if (clear) begin
      offset_q <= '0;
      index_q  <= '0;
    end else begin
      if (start && (index_q == 16'd0)) begin
        base_q <= base;
      end
      if (advance) begin
        if (is_last) begin
          index_q  <= '0;
          offset_q <= '0;
        end else begin
          index_q  <= index_q + 16'd1;
          offset_q <= offset_q + STEP;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_rw_burst_scheduler.sv
// Arbitrates one shared DDR AXI burst engine between the write-FIFO drain channel
// and the read-FIFO fill channel. It issues one burst at a time. A channel is eligible
// when its FIFO has a full burst of data or space. Ties are broken round-robin.
// Optional request-to-done watchdog: define DDR_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module ddr_rw_burst_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 11,
  parameter int BURST_LEN      = 64,
  parameter int BEAT_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           frame_bursts,
  input  logic [ADDR_WIDTH-1:0] wr_base_addr,
  input  logic [ADDR_WIDTH-1:0] rd_base_addr,
  input  logic [CNT_WIDTH-1:0]  wr_fifo_count,
  input  logic [CNT_WIDTH-1:0]  rd_fifo_space,
  ddr_rw_burst_scheduler_if.master eng,
  output logic                  wr_frame_end,
  output logic                  rd_frame_end,
  output logic                  busy,
  output logic                  timeout
);

  localparam int                   BURST_BYTES = burst_bytes(BURST_LEN, BEAT_BYTES);
  localparam logic [CNT_WIDTH-1:0] ELIG_LEVEL  = CNT_WIDTH'(BURST_LEN);

  state_e state_q, state_d;
  ch_e    last_grant_q, cur_ch_q, grant_ch;
  logic   grant, timed_out, tmo_hit;
  logic   wr_elig, rd_elig;

  // Next-state logic: threshold eligibility, round-robin grant and the handshake walk.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_ch  = CH_WR;
    timed_out = 1'b0;
    wr_elig   = (wr_fifo_count >= ELIG_LEVEL);
    rd_elig   = (rd_fifo_space >= ELIG_LEVEL);
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (wr_elig && rd_elig) begin
            grant    = 1'b1;
            grant_ch = (last_grant_q == CH_RD) ? CH_WR : CH_RD;
          end else if (wr_elig) begin
            grant    = 1'b1;
            grant_ch = CH_WR;
          end else if (rd_elig) begin
            grant    = 1'b1;
            grant_ch = CH_RD;
          end
        end
        if (grant) state_d = (grant_ch == CH_WR) ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (eng.wr_ack && eng.wr_done) state_d = ST_DONE;
        else if (eng.wr_ack)           state_d = ST_WR_WAIT;
        else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timed_out = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (eng.wr_done) state_d = ST_DONE;
        else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timed_out = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (eng.rd_ack && eng.rd_done) state_d = ST_DONE;
        else if (eng.rd_ack)           state_d = ST_RD_WAIT;
        else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timed_out = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (eng.rd_done) state_d = ST_DONE;
        else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timed_out = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, granted channel and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CH_RD;
      cur_ch_q     <= CH_WR;
    end else begin
      state_q <= state_d;
      if (grant) cur_ch_q <= grant_ch;
      if ((state_q == ST_DONE) || timed_out) last_grant_q <= cur_ch_q;
    end
  end

`ifdef DDR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;
  logic          in_burst;

  assign in_burst = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                    (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout  = timeout_q;

  // Watchdog counts cycles spent waiting on the engine. The flag stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (in_burst && !timed_out) ? tmo_cnt_q + TW'(1) : '0;
      if (timed_out) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // Moore outputs decoded from the state register, so reset clears them on the same edge.
  always_comb begin
    eng.wr_req = (state_q == ST_WR_REQ);
    eng.rd_req = (state_q == ST_RD_REQ);
    busy       = (state_q != ST_IDLE);
  end

  ddr_burst_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_BYTES (BURST_BYTES)
  ) u_wr_addr (
    .clk          (clk),
    .reset        (reset),
    .start        (grant && (grant_ch == CH_WR)),
    .advance      ((state_q == ST_DONE) && (cur_ch_q == CH_WR)),
    .clear        ((state_q == ST_IDLE) && !enable),
    .base         (wr_base_addr),
    .frame_bursts (frame_bursts),
    .addr         (eng.wr_addr),
    .frame_end    (wr_frame_end)
  );

  ddr_burst_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_BYTES (BURST_BYTES)
  ) u_rd_addr (
    .clk          (clk),
    .reset        (reset),
    .start        (grant && (grant_ch == CH_RD)),
    .advance      ((state_q == ST_DONE) && (cur_ch_q == CH_RD)),
    .clear        ((state_q == ST_IDLE) && !enable),
    .base         (rd_base_addr),
    .frame_bursts (frame_bursts),
    .addr         (eng.rd_addr),
    .frame_end    (rd_frame_end)
  );

endmodule
